unidade_controle_jogo: RTL and testbench

- Moore FSM that sequences the memory-game datapath (sequence counter, switch register, memory comparator) for one round of N plays.
- Detects a new play from the datapath's tem_jogada level, commands register load, compare and counter advance, and ends in hit, miss or timeout.
- Sits between top-level inputs (iniciar) and the datapath; drives pronto/acertou/errou and the db_estado hex display.

---
 rtl/jogo_pkg.sv | 60 ++++++
 rtl/detector_borda.sv | 35 +++
 rtl/unidade_controle_jogo.sv | 156 +++++++++++++++
 tb/tb_unidade_controle_jogo.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// rtl/jogo_pkg.sv - shared state codes and output decode for the memory-game control unit
//
// Purpose: 4-bit state codes (also the db_estado display value), default timeout
// constants, and the Moore output decode shared by the FSM and the benches.
// Ports: none (package).

package jogo_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARA     = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERRO    = 4'hE
  } estado_t;

  // 3 s at a 1 kHz clock.
  localparam int TIMEOUT_CICLOS_PADRAO = 3000;
  localparam int TMR_W_PADRAO          = 12;

  // Datapath commands and round status; timeout is kept apart because it only
  // exists when the timer is built.
  typedef struct packed {
    logic zera_c;
    logic conta_c;
    logic zera_r;
    logic registra_r;
    logic pronto;
    logic acertou;
    logic errou;
  } saidas_t;

  function automatic saidas_t decodifica_saidas(input estado_t estado);
    saidas_t s;
    s = '0;
    case (estado)
      PREPARACAO: begin
        s.zera_c = 1'b1;
        s.zera_r = 1'b1;
      end
      REGISTRA:   s.registra_r = 1'b1;
      PROXIMO:    s.conta_c = 1'b1;
      FIM_ACERTO: begin
        s.pronto  = 1'b1;
        s.acertou = 1'b1;
      end
      FIM_ERRO, FIM_TIMEOUT: begin
        s.pronto = 1'b1;
        s.errou  = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/detector_borda.sv
// rtl/detector_borda.sv - rising-edge detector for a synchronous level
//
// Purpose: registers the level every cycle and emits a one-cycle pulse when the
// level goes from 0 to 1.
// Ports:
//   clock  in  system clock, rising edge
//   reset  in  asynchronous active-low reset
//   sinal  in  level input, already synchronous to clock
//   borda  out one-cycle pulse on a rising edge of sinal

module detector_borda (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic borda
);

  logic sinal_d;
  logic sinal_q;

  always_comb begin
    sinal_d = sinal;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinal_q <= 1'b0;
    end else begin
      sinal_q <= sinal_d;
    end
  end

  assign borda = sinal & ~sinal_q;

endmodule

// File: rtl/unidade_controle_jogo.sv
// rtl/unidade_controle_jogo.sv - Moore FSM sequencing one round of the memory game
//
// Purpose: detects plays on tem_jogada, commands switch-register load, compare and
// counter advance, and ends the round in hit, miss or (optionally) timeout.
// Optional feature: define UNIDADE_CONTROLE_JOGO_TIMEOUT_EN to build the per-play
// timer and the FIM_TIMEOUT state; otherwise timeout is tied to 0.
// Ports:
//   clock       in  system clock, rising edge
//   reset       in  asynchronous active-low reset
//   iniciar     in  start/restart request (level)
//   tem_jogada  in  OR of the switches, synchronous to clock
//   igual       in  switch register equals memory data
//   fim         in  sequence counter at last address
//   zeraC       out clear sequence counter
//   contaC      out increment sequence counter
//   zeraR       out clear switch register
//   registraR   out load switch register
//   pronto      out round finished
//   acertou     out round won
//   errou       out round lost (miss or timeout)
//   timeout     out round lost by timeout
//   db_estado   out current state code for the hex display

module unidade_controle_jogo
  import jogo_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO,
  parameter int TMR_W          = TMR_W_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       tem_jogada,
  input  logic       igual,
  input  logic       fim,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  if ((64'd1 << TMR_W) < 64'(TIMEOUT_CICLOS)) begin : g_tmr_w_check
    $error("TMR_W too narrow for TIMEOUT_CICLOS");
  end

  logic jogada;

  detector_borda u_detector_borda (
    .clock (clock),
    .reset (reset),
    .sinal (tem_jogada),
    .borda (jogada)
  );

  estado_t estado_d;
  estado_t estado_q;
  saidas_t saidas_d;
  saidas_t saidas_q;

`ifdef UNIDADE_CONTROLE_JOGO_TIMEOUT_EN
  logic [TMR_W-1:0] timer_d;
  logic [TMR_W-1:0] timer_q;
  logic             timeout_d;
  logic             timeout_q;
  logic             timer_esgotado;

  assign timer_esgotado = (timer_q == TMR_W'(TIMEOUT_CICLOS - 1));
`endif

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:     if (iniciar) estado_d = PREPARACAO;
      PREPARACAO:  estado_d = ESPERA;
      ESPERA: begin
        // A play in the last allowed cycle beats the timeout.
        if (jogada) begin
          estado_d = REGISTRA;
        end
`ifdef UNIDADE_CONTROLE_JOGO_TIMEOUT_EN
        else if (timer_esgotado) begin
          estado_d = FIM_TIMEOUT;
        end
`endif
      end
      REGISTRA:    estado_d = COMPARA;
      COMPARA: begin
        if (!igual)   estado_d = FIM_ERRO;
        else if (fim) estado_d = FIM_ACERTO;
        else          estado_d = PROXIMO;
      end
      PROXIMO:     estado_d = ESPERA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
        if (iniciar) estado_d = PREPARACAO;
      end
      default:     estado_d = INICIAL;
    endcase
  end

  // Outputs are registered from the next state so that they are valid in the
  // same cycle the state is entered, exactly like a decode of estado_q.
  always_comb begin
    saidas_d = decodifica_saidas(estado_d);
  end

`ifdef UNIDADE_CONTROLE_JOGO_TIMEOUT_EN
  always_comb begin
    timer_d   = timer_q;
    timeout_d = (estado_d == FIM_TIMEOUT);
    case (estado_q)
      PREPARACAO, PROXIMO: timer_d = '0;
      ESPERA:              timer_d = timer_q + TMR_W'(1);
      default:             timer_d = timer_q;
    endcase
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= INICIAL;
      saidas_q  <= '0;
`ifdef UNIDADE_CONTROLE_JOGO_TIMEOUT_EN
      timer_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      estado_q  <= estado_d;
      saidas_q  <= saidas_d;
`ifdef UNIDADE_CONTROLE_JOGO_TIMEOUT_EN
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign zeraC     = saidas_q.zera_c;
  assign contaC    = saidas_q.conta_c;
  assign zeraR     = saidas_q.zera_r;
  assign registraR = saidas_q.registra_r;
  assign pronto    = saidas_q.pronto;
  assign acertou   = saidas_q.acertou;
  assign errou     = saidas_q.errou;
  assign db_estado = estado_q;

`ifdef UNIDADE_CONTROLE_JOGO_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// tb/tb_unidade_controle_jogo.sv - directed self-checking bench for unidade_controle_jogo

module tb_unidade_controle_jogo;

  // Output vector bit order: zeraC contaC zeraR registraR pronto acertou errou timeout
  localparam logic [7:0] O_NONE   = 8'h00;
  localparam logic [7:0] O_ZERA   = 8'hA0;
  localparam logic [7:0] O_REG    = 8'h10;
  localparam logic [7:0] O_CONTA  = 8'h40;
  localparam logic [7:0] O_ACERTO = 8'h0C;
  localparam logic [7:0] O_ERRO   = 8'h0A;
  localparam logic [7:0] O_TMO    = 8'h0B;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic       tem_jogada;
  logic       igual;
  logic       fim;
  logic       zeraC;
  logic       contaC;
  logic       zeraR;
  logic       registraR;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic [3:0] db_estado;

  int checks;
  int errors;

  unidade_controle_jogo #(
    .TIMEOUT_CICLOS (5),
    .TMR_W          (12)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .iniciar    (iniciar),
    .tem_jogada (tem_jogada),
    .igual      (igual),
    .fim        (fim),
    .zeraC      (zeraC),
    .contaC     (contaC),
    .zeraR      (zeraR),
    .registraR  (registraR),
    .pronto     (pronto),
    .acertou    (acertou),
    .errou      (errou),
    .timeout    (timeout),
    .db_estado  (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [3:0] st, input logic [7:0] outs);
    check({tag, "_st"}, 32'(db_estado), 32'(st));
    check({tag, "_out"}, 32'({zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}),
          32'(outs));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    iniciar    = 1'b0;
    tem_jogada = 1'b0;
    igual      = 1'b0;
    fim        = 1'b0;
    #12;
    expect_state("reset", 4'h0, O_NONE);
    tick();
    reset = 1'b1;
    tick();
    expect_state("idle", 4'h0, O_NONE);

    // Start: one PREPARACAO cycle, then ESPERA; iniciar held is ignored there.
    iniciar = 1'b1;
    tick();
    expect_state("prep", 4'h1, O_ZERA);
    tick();
    expect_state("espera", 4'h2, O_NONE);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_state("espera_ini_hold", 4'h2, O_NONE);
    end
    iniciar = 1'b0;

    // Three plays with a held level of 10 cycles each.
    igual = 1'b1;
    for (int p = 0; p < 3; p++) begin
      tem_jogada = 1'b1;
      tick();
      expect_state("play_reg", 4'h4, O_REG);
      tick();
      expect_state("play_cmp", 4'h5, O_NONE);
      tick();
      expect_state("play_prox", 4'h6, O_CONTA);
      tick();
      expect_state("play_back", 4'h2, O_NONE);
      for (int i = 0; i < 6; i++) begin
        tick();
        expect_state("play_held", 4'h2, O_NONE);
      end
      tem_jogada = 1'b0;
      tick();
      expect_state("play_release", 4'h2, O_NONE);
    end

    // Fourth play on the last address wins the round.
    fim        = 1'b1;
    tem_jogada = 1'b1;
    tick();
    expect_state("last_reg", 4'h4, O_REG);
    tick();
    expect_state("last_cmp", 4'h5, O_NONE);
    tick();
    expect_state("acerto", 4'hA, O_ACERTO);
    tem_jogada = 1'b0;
    tick();
    expect_state("acerto_hold", 4'hA, O_ACERTO);
    tem_jogada = 1'b1;
    tick();
    expect_state("acerto_edge_ignored", 4'hA, O_ACERTO);
    tem_jogada = 1'b0;
    tick();
    expect_state("acerto_hold2", 4'hA, O_ACERTO);

    // Restart with iniciar held: exactly one restart.
    iniciar = 1'b1;
    tick();
    expect_state("restart_prep", 4'h1, O_ZERA);
    tick();
    expect_state("restart_espera", 4'h2, O_NONE);
    tick();
    expect_state("restart_no_loop", 4'h2, O_NONE);
    iniciar = 1'b0;

    // Miss.
    fim        = 1'b0;
    igual      = 1'b0;
    tem_jogada = 1'b1;
    tick();
    expect_state("miss_reg", 4'h4, O_REG);
    tick();
    expect_state("miss_cmp", 4'h5, O_NONE);
    tick();
    expect_state("erro", 4'hE, O_ERRO);
    tem_jogada = 1'b0;
    tick();
    expect_state("erro_hold", 4'hE, O_ERRO);
    iniciar = 1'b1;
    tick();
    expect_state("erro_prep", 4'h1, O_ZERA);
    tick();
    expect_state("erro_espera", 4'h2, O_NONE);
    iniciar = 1'b0;

    // ESPERA entered on the edge above; the fifth following edge is the limit.
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_state("tmo_wait", 4'h2, O_NONE);
    end
    tick();
`ifdef UNIDADE_CONTROLE_JOGO_TIMEOUT_EN
    expect_state("tmo_fire", 4'hD, O_TMO);
    tick();
    expect_state("tmo_hold", 4'hD, O_TMO);
    iniciar = 1'b1;
    tick();
    expect_state("tmo_prep", 4'h1, O_ZERA);
    iniciar = 1'b0;
    tick();
    expect_state("tmo_espera", 4'h2, O_NONE);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_state("tmo_wait2", 4'h2, O_NONE);
    end
    // Play in the last allowed cycle wins over the timeout.
    tem_jogada = 1'b1;
    tick();
    expect_state("tmo_play_wins", 4'h4, O_REG);
`else
    expect_state("no_tmo", 4'h2, O_NONE);
    tem_jogada = 1'b1;
    tick();
    expect_state("late_play", 4'h4, O_REG);
`endif

    // Asynchronous reset in the middle of REGISTRA.
    #2;
    reset = 1'b0;
    #1;
    expect_state("async_reset", 4'h0, O_NONE);
    tem_jogada = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    expect_state("after_reset", 4'h0, O_NONE);
    tick();
    expect_state("after_reset_wait", 4'h0, O_NONE);
    iniciar = 1'b1;
    tick();
    expect_state("after_reset_start", 4'h1, O_ZERA);
    iniciar = 1'b0;
    tick();
    expect_state("after_reset_espera", 4'h2, O_NONE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
